axi4_lite_master: RTL and testbench
===================================

Name: axi4_lite_master

Overview:
- Command-driven AXI4-Lite master. It turns single-beat user write/read requests into AXI4-Lite transactions.
- Sits directly upstream of the slave wrapper: its m_* channel ports connect one-to-one to the slave's s_* ports.
- Handles one outstanding transaction at a time. It returns read data and response codes to the requester.

Parameters:
- ADDR_WIDTH, 32, address width of AW/AR channels and command address.
- DATA_WIDTH, 32, data width of W/R channels and command data; must be 32 or 64.

Ports:
- iCLK  in  1  clock; all logic on the rising edge.
- iRST  in  1  synchronous reset, active-high.
- iWR_REQ  in  1  write command strobe; sampled only when oBUSY=0.
- iRD_REQ  in  1  read command strobe; sampled only when oBUSY=0.
- iADDR  in  ADDR_WIDTH  command address.
- iWDATA  in  DATA_WIDTH  write data.
- iWSTRB  in  DATA_WIDTH/8  write byte strobes.
- iPROT  in  3  protection bits driven on AWPROT/ARPROT.
- oBUSY  out  1  transaction in flight; new commands are ignored.
- oDONE  out  1  one-cycle pulse at transaction completion.
- oRDATA  out  DATA_WIDTH  read data; valid with oDONE after a read; holds until the next read completes.
- oRESP  out  2  BRESP/RRESP of the completed transaction; valid with oDONE.
- m_AWVALID  out  1; m_AWREADY  in  1; m_AWADDR  out  ADDR_WIDTH; m_AWPROT  out  3.
- m_WVALID  out  1; m_WREADY  in  1; m_WDATA  out  DATA_WIDTH; m_WSTRB  out  DATA_WIDTH/8.
- m_BVALID  in  1; m_BREADY  out  1; m_BRESP  in  2.
- m_ARVALID  out  1; m_ARREADY  in  1; m_ARADDR  out  ADDR_WIDTH; m_ARPROT  out  3.
- m_RVALID  in  1; m_RREADY  out  1; m_RDATA  in  DATA_WIDTH; m_RRESP  in  2.

Behaviour:
- Reset (iRST=1 at an edge):
  - State = IDLE.
  - All m_*VALID = 0 and m_BREADY = m_RREADY = 0.
  - oBUSY = 0, oDONE = 0, oRDATA = 0, oRESP = 0.
  - Address/data/strobe/prot output registers = 0.
- Reset mid-transaction: aborts immediately and returns to IDLE in the same cycle. No further handshakes are issued.
- FSM states: IDLE, WR_AW_W, WR_B, RD_AR, RD_R.
- IDLE:
  - iWR_REQ=1: latch iADDR/iWDATA/iWSTRB/iPROT and go to WR_AW_W. Next cycle m_AWVALID = m_WVALID = 1 and oBUSY = 1.
  - Else iRD_REQ=1: latch iADDR/iPROT and go to RD_AR. Next cycle m_ARVALID = 1.
  - Both asserted in the same cycle: write wins. The read is dropped and must be re-issued.
- WR_AW_W:
  - AW and W are handshaked independently.
  - m_AWVALID deasserts the cycle after AWVALID&AWREADY; m_WVALID deasserts the cycle after WVALID&WREADY.
  - Go to WR_B once both handshakes have completed, including both in the same cycle.
  - Payloads stay stable while VALID is high. VALID is never withdrawn before READY.
- WR_B:
  - m_BREADY = 1.
  - On BVALID&BREADY: capture m_BRESP into oRESP, pulse oDONE, clear oBUSY, return to IDLE.
- RD_AR: on ARVALID&ARREADY, deassert m_ARVALID next cycle and go to RD_R.
- RD_R:
  - m_RREADY = 1.
  - On RVALID&RREADY: capture RDATA into oRDATA and RRESP into oRESP, pulse oDONE, return to IDLE.
- Latency with a zero-wait slave (READY high, response one cycle after address):
  - Write: command edge to oDONE = 4 cycles.
  - Read: command edge to oDONE = 4 cycles.
- Back-to-back commands:
  - oDONE and oBUSY=0 occur in the same cycle, so a command presented that cycle is accepted.
  - Minimum spacing between command accepts is therefore 4 cycles.
- No timeout. A stalled slave holds the master in its state indefinitely.
- Responses SLVERR (2'b10) and DECERR (2'b11) are passed through unmodified. No retry.
- Commands with oBUSY=1 are ignored, with no error indication.

Decomposition:
- Shared package axi4_lite_pkg:
  - Response codes RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11.
  - FSM state encoding constants (3-bit).
  - Default PROT value 3'b000.
- Single module, no sub-module. The AW/W done-flags stay inside the FSM.

Test Plan:
- Write 0xDEADBEEF to 0x0000_0010, WSTRB 4'hF, zero-wait slave -> one AW and one W handshake carrying those values; oDONE pulses 4 cycles after the command with oRESP=00; a subsequent read of 0x10 returns oRDATA=0xDEADBEEF.
- Slave holds WREADY low 3 cycles after AWREADY -> m_WVALID stays high with stable WDATA/WSTRB for those cycles; m_BREADY rises only after the W handshake; oDONE occurs once.
- Read of 0x0000_0004 with RVALID delayed 5 cycles, RRESP=SLVERR -> m_RREADY held high throughout; oRDATA captured on the handshake; oRESP=2'b10; oBUSY high until oDONE.
- iWR_REQ and iRD_REQ asserted together -> only a write transaction is issued; no ARVALID until a new iRD_REQ.
- iRST pulsed while in WR_B -> next cycle all VALID/READY = 0, oBUSY = 0, no oDONE; a new write completes normally.
- Command issued while oBUSY=1 -> ignored; no extra AW/AR handshake; exactly one oDONE for the original transaction.

Source files
------------

// File: rtl/axi4_lite_pkg.sv
// rtl/axi4_lite_pkg.sv - shared AXI4-Lite response codes, FSM states and defaults
package axi4_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [2:0] PROT_DEFAULT = 3'b000;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_AW_W = 3'd1,
        ST_WR_B    = 3'd2,
        ST_RD_AR   = 3'd3,
        ST_RD_R    = 3'd4
    } state_t;

endpackage

// File: rtl/axi4_lite_master.sv
// rtl/axi4_lite_master.sv - single-outstanding AXI4-Lite master driven by write/read command strobes
//
// Ports:
//   iCLK, iRST             clock, synchronous active-high reset
//   iWR_REQ, iRD_REQ       command strobes, sampled only while idle (write wins)
//   iADDR, iWDATA, iWSTRB  command address, write data, byte strobes
//   iPROT                  protection bits for AWPROT/ARPROT
//   oBUSY, oDONE           transaction in flight / one-cycle completion pulse
//   oRDATA, oRESP          read data (held until next read) and BRESP/RRESP
//   m_AW*, m_W*, m_B*      write address, write data, write response channels
//   m_AR*, m_R*            read address and read data channels
module axi4_lite_master
    import axi4_lite_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                      iCLK,
    input  logic                      iRST,
    input  logic                      iWR_REQ,
    input  logic                      iRD_REQ,
    input  logic [ADDR_WIDTH-1:0]     iADDR,
    input  logic [DATA_WIDTH-1:0]     iWDATA,
    input  logic [DATA_WIDTH/8-1:0]   iWSTRB,
    input  logic [2:0]                iPROT,
    output logic                      oBUSY,
    output logic                      oDONE,
    output logic [DATA_WIDTH-1:0]     oRDATA,
    output logic [1:0]                oRESP,
    output logic                      m_AWVALID,
    input  logic                      m_AWREADY,
    output logic [ADDR_WIDTH-1:0]     m_AWADDR,
    output logic [2:0]                m_AWPROT,
    output logic                      m_WVALID,
    input  logic                      m_WREADY,
    output logic [DATA_WIDTH-1:0]     m_WDATA,
    output logic [DATA_WIDTH/8-1:0]   m_WSTRB,
    input  logic                      m_BVALID,
    output logic                      m_BREADY,
    input  logic [1:0]                m_BRESP,
    output logic                      m_ARVALID,
    input  logic                      m_ARREADY,
    output logic [ADDR_WIDTH-1:0]     m_ARADDR,
    output logic [2:0]                m_ARPROT,
    input  logic                      m_RVALID,
    output logic                      m_RREADY,
    input  logic [DATA_WIDTH-1:0]     m_RDATA,
    input  logic [1:0]                m_RRESP
);

    state_t state;
    state_t state_next;

    // AW and W complete independently; these remember which one already has.
    logic aw_done;
    logic w_done;

    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH/8-1:0] wstrb_q;
    logic [2:0]              prot_q;

    logic aw_hs;
    logic w_hs;
    logic b_hs;
    logic ar_hs;
    logic r_hs;

    assign aw_hs = m_AWVALID && m_AWREADY;
    assign w_hs  = m_WVALID  && m_WREADY;
    assign b_hs  = m_BVALID  && m_BREADY;
    assign ar_hs = m_ARVALID && m_ARREADY;
    assign r_hs  = m_RVALID  && m_RREADY;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (iWR_REQ) begin
                    state_next = ST_WR_AW_W;
                end else if (iRD_REQ) begin
                    state_next = ST_RD_AR;
                end
            end
            ST_WR_AW_W: begin
                // Either handshake may land first, or both in the same cycle.
                if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                    state_next = ST_WR_B;
                end
            end
            ST_WR_B: begin
                if (b_hs) begin
                    state_next = ST_IDLE;
                end
            end
            ST_RD_AR: begin
                if (ar_hs) begin
                    state_next = ST_RD_R;
                end
            end
            ST_RD_R: begin
                if (r_hs) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        oBUSY     = (state != ST_IDLE);
        m_AWVALID = (state == ST_WR_AW_W) && !aw_done;
        m_WVALID  = (state == ST_WR_AW_W) && !w_done;
        m_BREADY  = (state == ST_WR_B);
        m_ARVALID = (state == ST_RD_AR);
        m_RREADY  = (state == ST_RD_R);
        m_AWADDR  = addr_q;
        m_ARADDR  = addr_q;
        m_AWPROT  = prot_q;
        m_ARPROT  = prot_q;
        m_WDATA   = wdata_q;
        m_WSTRB   = wstrb_q;
    end

    // Payload registers only load in IDLE, so they are stable while any VALID is high.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            prot_q  <= PROT_DEFAULT;
            oDONE   <= 1'b0;
            oRDATA  <= '0;
            oRESP   <= RESP_OKAY;
        end else begin
            oDONE <= 1'b0;
            case (state)
                ST_IDLE: begin
                    aw_done <= 1'b0;
                    w_done  <= 1'b0;
                    if (iWR_REQ) begin
                        addr_q  <= iADDR;
                        wdata_q <= iWDATA;
                        wstrb_q <= iWSTRB;
                        prot_q  <= iPROT;
                    end else if (iRD_REQ) begin
                        addr_q <= iADDR;
                        prot_q <= iPROT;
                    end
                end
                ST_WR_AW_W: begin
                    if (aw_hs) begin
                        aw_done <= 1'b1;
                    end
                    if (w_hs) begin
                        w_done <= 1'b1;
                    end
                end
                ST_WR_B: begin
                    if (b_hs) begin
                        oRESP <= m_BRESP;
                        oDONE <= 1'b1;
                    end
                end
                ST_RD_R: begin
                    if (r_hs) begin
                        oRDATA <= m_RDATA;
                        oRESP  <= m_RRESP;
                        oDONE  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_lite_master.sv
// tb/tb_axi4_lite_master.sv - randomized self-checking bench for axi4_lite_master
module tb_axi4_lite_master;
    import axi4_lite_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic          iCLK = 1'b0;
    logic          iRST = 1'b1;
    logic          iWR_REQ = 1'b0;
    logic          iRD_REQ = 1'b0;
    logic [AW-1:0] iADDR = '0;
    logic [DW-1:0] iWDATA = '0;
    logic [SW-1:0] iWSTRB = '0;
    logic [2:0]    iPROT = '0;
    logic          oBUSY;
    logic          oDONE;
    logic [DW-1:0] oRDATA;
    logic [1:0]    oRESP;
    logic          m_AWVALID;
    logic          m_AWREADY = 1'b0;
    logic [AW-1:0] m_AWADDR;
    logic [2:0]    m_AWPROT;
    logic          m_WVALID;
    logic          m_WREADY = 1'b0;
    logic [DW-1:0] m_WDATA;
    logic [SW-1:0] m_WSTRB;
    logic          m_BVALID = 1'b0;
    logic          m_BREADY;
    logic [1:0]    m_BRESP = 2'b00;
    logic          m_ARVALID;
    logic          m_ARREADY = 1'b0;
    logic [AW-1:0] m_ARADDR;
    logic [2:0]    m_ARPROT;
    logic          m_RVALID = 1'b0;
    logic          m_RREADY;
    logic [DW-1:0] m_RDATA = '0;
    logic [1:0]    m_RRESP = 2'b00;

    axi4_lite_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .iCLK(iCLK), .iRST(iRST), .iWR_REQ(iWR_REQ), .iRD_REQ(iRD_REQ),
        .iADDR(iADDR), .iWDATA(iWDATA), .iWSTRB(iWSTRB), .iPROT(iPROT),
        .oBUSY(oBUSY), .oDONE(oDONE), .oRDATA(oRDATA), .oRESP(oRESP),
        .m_AWVALID(m_AWVALID), .m_AWREADY(m_AWREADY), .m_AWADDR(m_AWADDR), .m_AWPROT(m_AWPROT),
        .m_WVALID(m_WVALID), .m_WREADY(m_WREADY), .m_WDATA(m_WDATA), .m_WSTRB(m_WSTRB),
        .m_BVALID(m_BVALID), .m_BREADY(m_BREADY), .m_BRESP(m_BRESP),
        .m_ARVALID(m_ARVALID), .m_ARREADY(m_ARREADY), .m_ARADDR(m_ARADDR), .m_ARPROT(m_ARPROT),
        .m_RVALID(m_RVALID), .m_RREADY(m_RREADY), .m_RDATA(m_RDATA), .m_RRESP(m_RRESP)
    );

    always #5 iCLK = ~iCLK;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Slave configuration, written only by the stimulus process.
    int         cfg_aw_delay = 0;
    int         cfg_w_delay  = 0;
    int         cfg_ar_delay = 0;
    int         cfg_b_delay  = 1;
    int         cfg_r_delay  = 1;
    logic [1:0] cfg_resp     = 2'b00;

    // Slave and monitor state, written only by the slave process.
    logic          rst_at_edge = 1'b1;
    bit            aw_fire, w_fire, ar_fire, b_fire, r_fire;
    bit            aw_stall, w_stall, ar_stall;
    bit            got_aw, got_w, b_pend, r_pend, w_seen;
    int            aw_wait, w_wait, ar_wait, b_wait, r_wait;
    int            aw_cnt = 0, w_cnt = 0, ar_cnt = 0, done_cnt = 0;
    int            proto_err = 0, bready_early = 0;
    logic [AW-1:0] cap_awaddr, cap_araddr, prev_awaddr, prev_araddr;
    logic [2:0]    cap_awprot, cap_arprot, prev_awprot, prev_arprot;
    logic [DW-1:0] cap_wdata, prev_wdata;
    logic [SW-1:0] cap_wstrb, prev_wstrb;
    logic [DW-1:0] slave_mem [int];

    always @(posedge iCLK) rst_at_edge <= iRST;

    always @(negedge iCLK) begin
        if (rst_at_edge) begin
            m_AWREADY = 0; m_WREADY = 0; m_ARREADY = 0; m_BVALID = 0; m_RVALID = 0;
            aw_fire = 0; w_fire = 0; ar_fire = 0; b_fire = 0; r_fire = 0;
            aw_stall = 0; w_stall = 0; ar_stall = 0;
            got_aw = 0; got_w = 0; b_pend = 0; r_pend = 0; w_seen = 0;
            aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
        end else begin
            if (aw_stall && (!m_AWVALID || m_AWADDR !== prev_awaddr || m_AWPROT !== prev_awprot)) proto_err++;
            if (w_stall && (!m_WVALID || m_WDATA !== prev_wdata || m_WSTRB !== prev_wstrb)) proto_err++;
            if (ar_stall && (!m_ARVALID || m_ARADDR !== prev_araddr || m_ARPROT !== prev_arprot)) proto_err++;
            if (oDONE) done_cnt++;
            if (aw_fire) begin aw_cnt++; got_aw = 1; aw_wait = 0; end
            if (w_fire) begin w_cnt++; got_w = 1; w_wait = 0; w_seen = 1; end
            if (got_aw && got_w) begin
                logic [DW-1:0] word;
                word = slave_mem.exists(int'(cap_awaddr)) ? slave_mem[int'(cap_awaddr)] : '0;
                for (int i = 0; i < SW; i++)
                    if (cap_wstrb[i]) word[8*i +: 8] = cap_wdata[8*i +: 8];
                slave_mem[int'(cap_awaddr)] = word;
                got_aw = 0; got_w = 0; b_pend = 1; b_wait = 0;
            end
            if (b_fire) begin m_BVALID = 0; w_seen = 0; end
            if (ar_fire) begin r_pend = 1; r_wait = 0; ar_wait = 0; ar_cnt++; end
            if (r_fire) m_RVALID = 0;
            if (m_BREADY && !w_seen) bready_early++;
            if (m_RVALID && !m_RREADY) proto_err++;
            if (m_BVALID && !m_BREADY) proto_err++;

            m_AWREADY = 0;
            if (m_AWVALID) begin
                if (aw_wait >= cfg_aw_delay) m_AWREADY = 1; else aw_wait++;
            end
            m_WREADY = 0;
            if (m_WVALID) begin
                if (w_wait >= cfg_w_delay) m_WREADY = 1; else w_wait++;
            end
            m_ARREADY = 0;
            if (m_ARVALID) begin
                if (ar_wait >= cfg_ar_delay) m_ARREADY = 1; else ar_wait++;
            end
            if (b_pend) begin
                if (b_wait >= cfg_b_delay) begin
                    m_BVALID = 1; m_BRESP = cfg_resp; b_pend = 0;
                end else b_wait++;
            end
            if (r_pend) begin
                if (r_wait >= cfg_r_delay) begin
                    m_RVALID = 1; m_RRESP = cfg_resp;
                    m_RDATA = slave_mem.exists(int'(cap_araddr)) ? slave_mem[int'(cap_araddr)] : '0;
                    r_pend = 0;
                end else r_wait++;
            end

            aw_fire = m_AWVALID && m_AWREADY;
            w_fire  = m_WVALID && m_WREADY;
            ar_fire = m_ARVALID && m_ARREADY;
            b_fire  = m_BVALID && m_BREADY;
            r_fire  = m_RVALID && m_RREADY;
            if (aw_fire) begin cap_awaddr = m_AWADDR; cap_awprot = m_AWPROT; end
            if (w_fire) begin cap_wdata = m_WDATA; cap_wstrb = m_WSTRB; end
            if (ar_fire) begin cap_araddr = m_ARADDR; cap_arprot = m_ARPROT; end
            aw_stall = m_AWVALID && !m_AWREADY;
            w_stall  = m_WVALID && !m_WREADY;
            ar_stall = m_ARVALID && !m_ARREADY;
            prev_awaddr = m_AWADDR; prev_awprot = m_AWPROT;
            prev_wdata = m_WDATA; prev_wstrb = m_WSTRB;
            prev_araddr = m_ARADDR; prev_arprot = m_ARPROT;
        end
    end

    // Reference model: a word-addressed memory updated with byte-mask arithmetic.
    logic [DW-1:0] ref_mem [int];

    function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : '0;
    endfunction

    task automatic ref_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
        logic [DW-1:0] mask;
        mask = '0;
        for (int i = 0; i < SW; i++) mask = mask | ({DW{s[i]}} & (DW'(8'hFF) << (8 * i)));
        ref_mem[int'(a)] = (ref_read(a) & ~mask) | (d & mask);
    endtask

    logic [DW-1:0] last_rdata = '0;

    // Presents a command at the current negedge and returns at the negedge where oDONE is seen.
    task automatic do_cmd(input bit wr, input bit rd, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [SW-1:0] s, input logic [2:0] p, input logic [1:0] resp,
                          input string tag, output int lat);
        int busy_low;
        busy_low = 0;
        cfg_resp = resp;
        iWR_REQ = wr; iRD_REQ = rd; iADDR = a; iWDATA = d; iWSTRB = s; iPROT = p;
        @(negedge iCLK);
        iWR_REQ = 0; iRD_REQ = 0;
        lat = 1;
        while (!oDONE && lat < 300) begin
            if (!oBUSY) busy_low++;
            @(negedge iCLK);
            lat++;
        end
        check({tag, "_done"}, oDONE, 1'b1);
        check({tag, "_busy_hold"}, busy_low, 0);
        check({tag, "_resp"}, oRESP, resp);
        if (wr) begin
            check({tag, "_awaddr"}, cap_awaddr, a);
            check({tag, "_awprot"}, cap_awprot, p);
            check({tag, "_wdata"}, cap_wdata, d);
            check({tag, "_wstrb"}, cap_wstrb, s);
            ref_write(a, d, s);
            check({tag, "_rdata_hold"}, oRDATA, last_rdata);
        end else begin
            check({tag, "_araddr"}, cap_araddr, a);
            check({tag, "_arprot"}, cap_arprot, p);
            last_rdata = ref_read(a);
            check({tag, "_rdata"}, oRDATA, last_rdata);
        end
    endtask

    task automatic set_delays(input int awd, input int wd, input int ard, input int bd, input int rd);
        cfg_aw_delay = awd; cfg_w_delay = wd; cfg_ar_delay = ard; cfg_b_delay = bd; cfg_r_delay = rd;
    endtask

    initial begin
        int lat, n0, a0, r0, bound;
        repeat (3) @(negedge iCLK);
        check("reset_outs", {oBUSY, oDONE, m_AWVALID, m_WVALID, m_ARVALID, m_BREADY, m_RREADY}, 7'b0);
        check("reset_rdata_resp", {oRDATA, oRESP}, 34'b0);
        check("reset_payload", {m_AWADDR, m_WDATA, m_WSTRB, m_AWPROT}, 71'b0);
        iRST = 0;
        @(negedge iCLK);

        set_delays(0, 0, 0, 1, 1);
        a0 = aw_cnt;
        do_cmd(1, 0, 32'h10, 32'hDEADBEEF, 4'hF, 3'b000, RESP_OKAY, "wr_basic", lat);
        check("wr_basic_latency", lat, 4);
        do_cmd(0, 1, 32'h10, 32'h0, 4'h0, 3'b000, RESP_OKAY, "rd_basic", lat);
        check("rd_basic_latency", lat, 4);
        check("rd_basic_value", oRDATA, 32'hDEADBEEF);
        check("wr_basic_aw_count", aw_cnt - a0, 1);

        set_delays(0, 3, 0, 1, 1);
        @(negedge iCLK);
        n0 = done_cnt;
        do_cmd(1, 0, 32'h20, 32'h12345678, 4'b0101, 3'b010, RESP_OKAY, "wr_wstall", lat);
        repeat (2) @(negedge iCLK);
        check("wr_wstall_done_once", done_cnt - n0, 1);

        set_delays(0, 0, 0, 1, 5);
        do_cmd(0, 1, 32'h4, 32'h0, 4'h0, 3'b001, RESP_SLVERR, "rd_slverr", lat);
        check("rd_slverr_latency", lat, 8);

        set_delays(0, 0, 0, 1, 1);
        @(negedge iCLK);
        a0 = aw_cnt; r0 = ar_cnt;
        do_cmd(1, 1, 32'h8, 32'hA5A5_0F0F, 4'hF, 3'b100, RESP_DECERR, "wr_and_rd", lat);
        repeat (3) @(negedge iCLK);
        check("both_req_aw", aw_cnt - a0, 1);
        check("both_req_no_ar", ar_cnt - r0, 0);

        // Reset while waiting for the write response.
        set_delays(0, 0, 0, 8, 1);
        n0 = done_cnt;
        iWR_REQ = 1; iADDR = 32'h40; iWDATA = 32'hCAFE_F00D; iWSTRB = 4'hF; iPROT = 3'b000;
        @(negedge iCLK);
        iWR_REQ = 0;
        bound = 0;
        while (!m_BREADY && bound < 20) begin @(negedge iCLK); bound++; end
        check("rst_mid_reached_wr_b", m_BREADY, 1'b1);
        ref_write(32'h40, 32'hCAFE_F00D, 4'hF);
        iRST = 1;
        @(negedge iCLK);
        iRST = 0;
        check("rst_mid_outs", {oBUSY, oDONE, m_AWVALID, m_WVALID, m_ARVALID, m_BREADY, m_RREADY}, 7'b0);
        repeat (12) @(negedge iCLK);
        check("rst_mid_no_done", done_cnt - n0, 0);
        last_rdata = '0;
        set_delays(0, 0, 0, 1, 1);
        do_cmd(1, 0, 32'h44, 32'h0BAD_CAFE, 4'hF, 3'b000, RESP_OKAY, "wr_after_rst", lat);
        check("wr_after_rst_latency", lat, 4);

        // Commands while busy are dropped.
        set_delays(0, 0, 2, 1, 4);
        @(negedge iCLK);
        n0 = done_cnt; a0 = aw_cnt; r0 = ar_cnt;
        iRD_REQ = 1; iADDR = 32'h20; iPROT = 3'b000;
        @(negedge iCLK);
        iRD_REQ = 0;
        repeat (3) begin
            iWR_REQ = 1; iRD_REQ = 1; iADDR = 32'h30; iWDATA = 32'hFFFF_FFFF; iWSTRB = 4'hF;
            @(negedge iCLK);
        end
        iWR_REQ = 0; iRD_REQ = 0;
        bound = 0;
        while (!oDONE && bound < 50) begin @(negedge iCLK); bound++; end
        check("busy_rd_value", oRDATA, ref_read(32'h20));
        last_rdata = ref_read(32'h20);
        repeat (4) @(negedge iCLK);
        check("busy_ignore_aw", aw_cnt - a0, 0);
        check("busy_ignore_ar", ar_cnt - r0, 1);
        check("busy_one_done", done_cnt - n0, 1);

        // Randomized back-to-back traffic.
        for (int t = 0; t < 40; t++) begin
            bit zero_wait, wr;
            logic [1:0] resp;
            zero_wait = ($urandom_range(0, 1) == 1);
            if (zero_wait) set_delays(0, 0, 0, 1, 1);
            else set_delays($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                            $urandom_range(1, 3), $urandom_range(1, 3));
            wr = ($urandom_range(0, 1) == 1);
            resp = 2'($urandom_range(0, 3));
            do_cmd(wr, !wr, AW'($urandom_range(0, 15) * 4), DW'($urandom), SW'($urandom),
                   3'($urandom), resp, $sformatf("rnd%0d", t), lat);
            if (zero_wait) check($sformatf("rnd%0d_latency", t), lat, 4);
        end

        repeat (4) @(negedge iCLK);
        check("protocol_stability", proto_err, 0);
        check("bready_before_w", bready_early, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
